// File: rtl/eight_bit_multiplier.sv
// Registered 8x8 integer multiplier: operand register, full-adder partial-product array, product register.
// Define MULT_SIGNED_EN for a two's-complement (Baugh-Wooley) array instead of the default unsigned one.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module eight_bit_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] out,
    output logic        out_valid
);
    // Handshake: in_valid qualifies a/b on the edge they are sampled; out_valid is high for
    // exactly one cycle per accepted pair, two edges later, with out valid in that same cycle.
    // There is no ready signal, so every pair is accepted and the consumer must take every result.

`ifdef MULT_SIGNED_EN
    // Extra row carries the Baugh-Wooley correction constants (2^8 + 2^15).
    localparam int ROWS = 9;
`else
    localparam int ROWS = 8;
`endif

    logic [7:0]             a_q;
    logic [7:0]             b_q;
    logic                   v1;
    logic [ROWS-1:0][15:0]  rows;
    logic [ROWS-1:0][15:0]  acc;
    logic [ROWS-1:1][15:0]  carry;
    logic [15:0]            product;

    always_comb begin
        rows = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
`ifdef MULT_SIGNED_EN
                // Cross terms between one sign bit and one magnitude bit are complemented.
                if ((i == 7) != (j == 7))
                    rows[i][i+j] = ~(a_q[j] & b_q[i]);
                else
                    rows[i][i+j] = a_q[j] & b_q[i];
`else
                rows[i][i+j] = a_q[j] & b_q[i];
`endif
            end
        end
`ifdef MULT_SIGNED_EN
        rows[8] = 16'h8100;
`endif
    end

    assign acc[0] = rows[0];

    // Each row is added into the running sum with a 16-bit ripple of full adders; the top bit
    // needs no carry-out because the result is taken modulo 2^16.
    for (genvar k = 1; k < ROWS; k++) begin : g_row
        assign carry[k][0] = 1'b0;
        for (genvar n = 0; n < 15; n++) begin : g_bit
            full_adder u_fa (
                .x    (acc[k-1][n]),
                .y    (rows[k][n]),
                .cin  (carry[k][n]),
                .s    (acc[k][n]),
                .cout (carry[k][n+1])
            );
        end
        assign acc[k][15] = acc[k-1][15] ^ rows[k][15] ^ carry[k][15];
    end

    assign product = acc[ROWS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            v1        <= 1'b0;
            out       <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            a_q       <= a;
            b_q       <= b;
            v1        <= in_valid;
            out_valid <= v1;
            if (v1)
                out <= product;
        end
    end
endmodule

// File: tb/tb_eight_bit_multiplier.sv
// Self-checking bench for eight_bit_multiplier: directed, extreme, streaming, reset and sweep cases
// checked against an arithmetic reference model and an expected-product queue.

module tb_eight_bit_multiplier;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;
    logic        out_valid;

    int n_checks;
    int n_pass;

    logic [15:0] exp_q[$];
    logic        pend_v;
    logic        exp_valid;
    logic [15:0] exp_out;
    logic [15:0] last_prod;

    eight_bit_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
`ifdef MULT_SIGNED_EN
        p = $signed(x) * $signed(y);
`else
        p = int'(x) * int'(y);
`endif
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare outputs 1 ns later.
    task automatic step(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y);
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        exp_valid = !r && pend_v;
        if (r) begin
            exp_q.delete();
            exp_out = 16'h0000;
        end else if (exp_valid) begin
            if (exp_q.size() == 0) begin
                $display("FAIL queue: got 0x%04h expected 0x%04h (model queue empty)", out, 16'h0000);
                n_checks++;
            end else begin
                exp_out = exp_q.pop_front();
            end
        end
        if (!r && v)
            exp_q.push_back(ref_mul(x, y));
        pend_v = !r && v;
        #1;
        check("out_valid", {15'd0, out_valid}, {15'd0, exp_valid});
        check("out", out, exp_out);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    vec_t dir[6];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pend_v   = 1'b0;
        exp_out  = 16'h0000;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;

`ifdef MULT_SIGNED_EN
        dir[0] = '{8'h00, 8'h00, 16'h0000};
        dir[1] = '{8'h05, 8'hD6, 16'hFF2E};
        dir[2] = '{8'hAD, 8'h29, 16'hF2B5};
        dir[3] = '{8'hFF, 8'hFF, 16'h0001};
        dir[4] = '{8'h80, 8'h80, 16'h4000};
        dir[5] = '{8'h01, 8'h7F, 16'h007F};
`else
        dir[0] = '{8'h00, 8'h00, 16'h0000};
        dir[1] = '{8'h05, 8'hD6, 16'h042E};
        dir[2] = '{8'hAD, 8'h29, 16'h1BB5};
        dir[3] = '{8'hFF, 8'hFF, 16'hFE01};
        dir[4] = '{8'h80, 8'h80, 16'h4000};
        dir[5] = '{8'h01, 8'h7F, 16'h007F};
`endif

        // Reset held two cycles with live-looking traffic.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // First pair after reset: no valid one edge later, valid two edges later.
        step(1'b0, 1'b1, 8'h03, 8'h07);
        idle();
        check("first_result", out, 16'h0015);
        idle();

        // Directed and extreme products against literal values, each two edges after capture.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, dir[i].x, dir[i].y);
            idle();
            check("directed_valid", {15'd0, out_valid}, 16'h0001);
            check("directed", out, dir[i].p);
        end
        idle();

        // Streaming 16 back-to-back random pairs, then drop in_valid.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            last_prod = ref_mul(x, y);
            step(1'b0, 1'b1, x, y);
        end
        idle();
        idle();
        check("hold_after_stream", out, last_prod);
        idle();
        check("hold_valid_low", {15'd0, out_valid}, 16'h0000);

        // Reset while pairs are in flight: nothing emerges afterwards.
        step(1'b0, 1'b1, 8'h11, 8'h22);
        step(1'b1, 1'b1, 8'h33, 8'h44);
        check("reset_mid_out", out, 16'h0000);
        idle();
        check("reset_mid_valid", {15'd0, out_valid}, 16'h0000);
        idle();
        check("reset_mid_valid2", {15'd0, out_valid}, 16'h0000);
        check("reset_mid_out2", out, 16'h0000);

        // Random gaps in the valid stream.
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));

        // Exhaustive sweep of every operand pair.
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 256; j++)
                step(1'b0, 1'b1, 8'(i), 8'(j));
        idle();
        idle();
        check("sweep_drained", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/eight_bit_multiplier.md
Name: eight_bit_multiplier

Overview:
- Registered 8x8 unsigned integer multiplier producing a full-precision 16-bit product.
- Used as an arithmetic leaf block in the datapath.
- The product is formed from eight AND-gated partial products summed by an adder array; no truncation or rounding.
- Inputs and product are registered, giving a fixed two-cycle latency with a valid flag.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits.

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a and b in the current cycle
- a  input  8  multiplicand
- b  input  8  multiplier
- out  output  16  product a*b, registered
- out_valid  output  1  high for one cycle per accepted operand pair, aligned with out

Behaviour:
- Reset: the only synchronous state is the set of registers listed below. On a clk edge with rst=1, all of them clear to 0:
  - operand registers a_q, b_q
  - stage-1 valid v1
  - out (0x0000)
  - out_valid (0)
- Reset has priority over all other activity. Reset mid-operation discards every in-flight pair, and no out_valid is produced for those pairs.
- Stage 1: every clk edge with rst=0 does a_q<=a, b_q<=b, v1<=in_valid. Operands are captured regardless of in_valid.
- Stage 2, when v1=1: out<=a_q*b_q and out_valid<=1.
- Stage 2, when v1=0: out holds its previous value and out_valid<=0.
- Latency: operands presented with in_valid at edge N appear on out with out_valid=1 after edge N+1, i.e. two rising edges after capture.
- Throughput: one product per cycle. Back-to-back in_valid pulses produce back-to-back results in order.
- No backpressure: the block always accepts input, and a downstream consumer must take out when out_valid=1.
- Arithmetic: the default is unsigned, with out = a*b exactly over 0..65025. Overflow is impossible.
  - Partial product i = (a_q & {8{b_q[i]}}) << i, for i=0..7.
  - The partial products are summed by a ripple or carry-save array of full adders built as a separate full_adder submodule.
  - Use of the synthesis '*' operator in the array is not permitted.
- Boundaries: operand 0 gives 0x0000. 0xFF*0xFF gives 0xFE01. 1*x gives zero-extended x.
- No X propagation is allowed from out after the first reset.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- When MULT_SIGNED_EN is defined:
  - a and b are treated as two's-complement signed values in -128..127.
  - out is the 16-bit two's-complement product.
  - The implementation uses Baugh-Wooley sign handling in the partial-product array.
  - Latency and handshake are unchanged.
  - Example: 0xFF*0xFF gives 0x0001.
- When MULT_SIGNED_EN is undefined: unsigned behaviour as above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random a/b and in_valid=1 -> out=0x0000 and out_valid=0 throughout. The first out_valid appears 2 edges after rst deasserts with in_valid=1.
- Directed products with in_valid=1:
  - a=0x00, b=0x00 -> out=0x0000.
  - a=0x05, b=0xD6 -> 0x042E (1070), or 0xFF2E with MULT_SIGNED_EN.
  - a=0xAD, b=0x29 -> 0x1BB5 (7093), or 0xF2B5 with MULT_SIGNED_EN.
  - Each result must appear exactly 2 edges after capture.
- Extremes:
  - 0xFF*0xFF -> 0xFE01 (0x0001 with MULT_SIGNED_EN).
  - 0x80*0x80 -> 0x4000 in both modes.
  - 0x01*0x7F -> 0x007F.
- Streaming: 16 consecutive random pairs with in_valid=1 -> 16 consecutive out_valid cycles, each equal to the reference model and in order. Then drop in_valid -> out holds the last product and out_valid=0.
- Reset mid-stream: assert rst for one cycle while 2 pairs are in flight -> neither produces out_valid; out=0x0000 on the next cycle.
- Exhaustive unsigned sweep: all 65536 pairs, compared to a*b after 2-cycle alignment -> zero mismatches.
